// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges the single-cycle execute result (A, priority) and a
// FIFO-buffered long-latency result stream (B) into the register file write port.
module wb_arbiter #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       a_valid,
  input  logic [4:0]                 a_rd,
  input  logic [N-1:0]               a_data,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [4:0]                 b_rd,
  input  logic [N-1:0]               b_data,
  output logic [4:0]                 rd,
  output logic [N-1:0]               write_data,
  output logic                       write_enable,
  input  logic [4:0]                 q_rs1,
  input  logic [4:0]                 q_rs2,
  output logic                       q_hit1,
  output logic                       q_hit2,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    rd_mem   [DEPTH];
  logic [N-1:0]  data_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic a_sel;
  logic pop;
  logic push;
  logic fifo_hit1;
  logic fifo_hit2;
  logic [PW-1:0] idx;

  // A with rd=0 still owns the slot, so any a_valid blocks the pop.
  assign a_sel   = a_valid && (a_rd != 5'd0);
  assign pop     = !a_valid && (count != '0);
  assign b_ready = rst_n && (count < CW'(DEPTH));
  assign push    = b_valid && b_ready && (b_rd != 5'd0);

  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      write_enable <= 1'b0;
      rd           <= 5'd0;
      write_data   <= '0;
    end else begin
      if (push) begin
        rd_mem[wr_ptr]   <= b_rd;
        data_mem[wr_ptr] <= b_data;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (!push && pop) begin
        count <= count - CW'(1);
      end
      if (a_sel) begin
        write_enable <= 1'b1;
        rd           <= a_rd;
        write_data   <= a_data;
      end else if (pop) begin
        write_enable <= 1'b1;
        rd           <= rd_mem[rd_ptr];
        write_data   <= data_mem[rd_ptr];
      end else begin
        write_enable <= 1'b0;
      end
    end
  end

  // Scan only the occupied slots, walking forward from the read pointer.
  always_comb begin
    fifo_hit1 = 1'b0;
    fifo_hit2 = 1'b0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (CW'(k) < count) begin
        if (rd_mem[idx] == q_rs1) fifo_hit1 = 1'b1;
        if (rd_mem[idx] == q_rs2) fifo_hit2 = 1'b1;
      end
    end
  end

  assign q_hit1 = (q_rs1 != 5'd0) && (fifo_hit1 || (write_enable && (rd == q_rs1)));
  assign q_hit2 = (q_rs2 != 5'd0) && (fifo_hit2 || (write_enable && (rd == q_rs2)));

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios followed by random traffic, all
// checked each cycle against a queue-based reference model.
module tb_wb_arbiter;

  localparam int N     = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid;
  logic [4:0]    a_rd;
  logic [N-1:0]  a_data;
  logic          b_valid;
  logic          b_ready;
  logic [4:0]    b_rd;
  logic [N-1:0]  b_data;
  logic [4:0]    rd;
  logic [N-1:0]  write_data;
  logic          write_enable;
  logic [4:0]    q_rs1;
  logic [4:0]    q_rs2;
  logic          q_hit1;
  logic          q_hit2;
  logic [CW-1:0] fifo_count;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [4:0]   rd;
    logic [N-1:0] data;
  } entry_t;

  entry_t       mq[$];
  logic         m_we;
  logic [4:0]   m_rd;
  logic [N-1:0] m_data;

  always #5 clk = ~clk;

  wb_arbiter #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .rd(rd), .write_data(write_data), .write_enable(write_enable),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_hit1(q_hit1), .q_hit2(q_hit2),
    .fifo_count(fifo_count)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic modelHit(input logic [4:0] q);
    if (q == 5'd0) return 1'b0;
    if (m_we && m_rd == q) return 1'b1;
    foreach (mq[i]) if (mq[i].rd == q) return 1'b1;
    return 1'b0;
  endfunction

  task automatic checkOutput();
    checkVal("write_enable", write_enable, m_we);
    if (m_we) begin
      checkVal("rd", rd, m_rd);
      checkVal("write_data", write_data, m_data);
    end
    checkVal("b_ready", b_ready, rst_n && (mq.size() < DEPTH));
    checkVal("fifo_count", fifo_count, mq.size());
    checkVal("q_hit1", q_hit1, modelHit(q_rs1));
    checkVal("q_hit2", q_hit2, modelHit(q_rs2));
  endtask

  // Reference behaviour for one clock edge, using the inputs held across it.
  task automatic modelStep();
    bit     ready;
    entry_t e;
    ready = (mq.size() < DEPTH);
    if (!rst_n) begin
      mq.delete();
      m_we   = 1'b0;
      m_rd   = 5'd0;
      m_data = '0;
    end else begin
      if (a_valid && a_rd != 5'd0) begin
        m_we   = 1'b1;
        m_rd   = a_rd;
        m_data = a_data;
      end else if (!a_valid && mq.size() > 0) begin
        e      = mq.pop_front();
        m_we   = 1'b1;
        m_rd   = e.rd;
        m_data = e.data;
      end else begin
        m_we = 1'b0;
      end
      if (b_valid && ready && b_rd != 5'd0) mq.push_back({b_rd, b_data});
    end
  endtask

  task automatic applyStimulus(input logic rn, input logic av, input logic [4:0] ar,
                               input logic [31:0] ad, input logic bv, input logic [4:0] br,
                               input logic [31:0] bd, input logic [4:0] q1, input logic [4:0] q2);
    rst_n   = rn;
    a_valid = av;
    a_rd    = ar;
    a_data  = ad;
    b_valid = bv;
    b_rd    = br;
    b_data  = bd;
    q_rs1   = q1;
    q_rs2   = q2;
    #1;
    checkOutput();
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic idle(input logic [4:0] q1, input logic [4:0] q2);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, q1, q2);
  endtask

  initial begin
    logic [4:0] r1;
    logic [4:0] r2;
    rst_n = 1'b0; a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0; q_rs1 = '0; q_rs2 = '0;
    m_we = 1'b0; m_rd = '0; m_data = '0;

    @(negedge clk);
    @(posedge clk);
    modelStep();
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    checkVal("reset_we", write_enable, 1'b0);
    checkVal("reset_rd", rd, 5'd0);
    checkVal("reset_data", write_data, 32'd0);
    checkVal("reset_count", fifo_count, 0);

    // Single A write appears for exactly one cycle.
    applyStimulus(1'b1, 1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    checkVal("t1_we", write_enable, 1'b1);
    checkVal("t1_rd", rd, 5'd5);
    checkVal("t1_data", write_data, 32'h11);
    idle(5'd0, 5'd0);
    checkVal("t1_we_off", write_enable, 1'b0);

    // Single B result, two-cycle latency.
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAB, 5'd0, 5'd0);
    checkVal("t2_count", fifo_count, 1);
    idle(5'd0, 5'd0);
    checkVal("t2_we", write_enable, 1'b1);
    checkVal("t2_rd", rd, 5'd7);
    checkVal("t2_data", write_data, 32'hAB);
    checkVal("t2_count_empty", fifo_count, 0);

    // Fill the FIFO while A holds the port, then drain in order.
    for (int i = 1; i <= 4; i++)
      applyStimulus(1'b1, 1'b1, 5'd9, 32'h90 + i, 1'b1, 5'(i), 32'hB0 + i, 5'd0, 5'd0);
    checkVal("t3_full", fifo_count, 4);
    checkVal("t3_ready_low", b_ready, 1'b0);
    checkVal("t3_a_rd", rd, 5'd9);
    idle(5'd0, 5'd0);
    checkVal("t3_first_pop", rd, 5'd1);
    checkVal("t3_ready_back", b_ready, 1'b1);
    for (int i = 0; i < 3; i++) idle(5'd0, 5'd0);

    // Zero destinations on both sources write nothing.
    applyStimulus(1'b1, 1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66, 5'd0, 5'd0);
    checkVal("t4_count", fifo_count, 0);
    checkVal("t4_we", write_enable, 1'b0);
    idle(5'd0, 5'd0);

    // Hazard query tracks rd=12 through the FIFO and the output stage.
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC0, 5'd12, 5'd0);
    applyStimulus(1'b1, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0, 5'd12, 5'd0);
    checkVal("t5_hit1", q_hit1, 1'b1);
    checkVal("t5_hit2", q_hit2, 1'b0);
    idle(5'd12, 5'd0);
    idle(5'd12, 5'd0);
    idle(5'd12, 5'd0);

    // Reset discards a partially filled FIFO.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b1, 5'd8, 32'h80, 1'b1, 5'(20 + i), 32'hD0 + i, 5'd21, 5'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd25, 32'hEE, 5'd21, 5'd0);
    checkVal("t6_count", fifo_count, 0);
    checkVal("t6_we", write_enable, 1'b0);
    idle(5'd21, 5'd20);
    checkVal("t6_ready", b_ready, 1'b1);
    for (int i = 0; i < 3; i++) idle(5'd21, 5'd20);

    // Pointer wrap: fill, then sustained push+pop.
    for (int i = 1; i <= DEPTH; i++)
      applyStimulus(1'b1, 1'b1, 5'd2, 32'h22, 1'b1, 5'(i), 32'hF0 + i, 5'd0, 5'd0);
    for (int i = 0; i < DEPTH + 4; i++)
      applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'(10 + i), 32'hA00 + i, 5'(10 + i), 5'd3);
    for (int i = 0; i < DEPTH + 2; i++) idle(5'd11, 5'd0);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      r1 = (mq.size() > 0 && $urandom_range(1, 0) == 1) ? mq[0].rd : 5'($urandom_range(31, 0));
      r2 = 5'($urandom_range(31, 0));
      applyStimulus(($urandom_range(63, 0) != 0),
                    ($urandom_range(99, 0) < 40),
                    ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1)),
                    $urandom(),
                    ($urandom_range(99, 0) < 60),
                    ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1)),
                    $urandom(),
                    r1, r2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
